// File: rtl/load_store_unit.sv
// Load/store unit: sits between the ALU/control path and a word-only data
// memory. Adds RV32I byte/halfword loads (with sign or zero extension) and
// byte/halfword stores done as a registered two-cycle read-modify-write.
// Misaligned or illegal accesses are blocked and reported as a fault.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] MemReadData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWE,
  output logic [DATA_W-1:0] LoadData,
  output logic              Stall,
  output logic              MisalignedFault,
  output logic              FaultSticky
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t              state, next_state;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_word;
  logic                capture;

  logic [1:0]          off;
  logic                is_half, is_word;
  logic                misaligned, load_illegal, store_illegal, fault_req;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [DATA_W-1:0]   load_value;
  logic [DATA_W-1:0]   merged;

  // Access decode: byte offset, size class and fault conditions.
  assign off           = ALUResult[1:0];
  assign is_half       = (funct3[1:0] == 2'b01);
  assign is_word       = (funct3 == 3'b010);
  assign misaligned    = (is_half && off[0]) || (is_word && (off != 2'b00));
  assign load_illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  assign store_illegal = funct3[2] || (funct3 == 3'b011);
  assign fault_req     = (MemRead && MemWrite)
                       || (MemRead && (load_illegal || misaligned))
                       || (MemWrite && (store_illegal || misaligned));

  // Load extraction: pick the addressed byte/halfword and extend it.
  always_comb begin
    byte_sel   = MemReadData[{off, 3'b000} +: 8];
    half_sel   = MemReadData[{off[1], 4'b0000} +: 16];
    load_value = '0;
    case (funct3)
      3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_value = MemReadData;
      3'b100:  load_value = {24'h000000, byte_sel};
      3'b101:  load_value = {16'h0000, half_sel};
      default: load_value = '0;
    endcase
  end

  // Store merge: current memory word with the target byte/halfword replaced.
  always_comb begin
    merged = MemReadData;
    if (funct3[0]) merged[{off[1], 4'b0000} +: 16] = WriteData[15:0];
    else           merged[{off, 3'b000} +: 8]      = WriteData[7:0];
  end

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and output decode.
  // NOTE: every output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    next_state      = state;
    MemAddr         = {ALUResult[ADDR_W-1:2], 2'b00};
    MemWriteData    = WriteData;
    MemWE           = 1'b0;
    Stall           = 1'b0;
    MisalignedFault = 1'b0;
    LoadData        = '0;
    capture         = 1'b0;
    case (state)
      IDLE: begin
        if (fault_req) begin
          MisalignedFault = 1'b1;
        end else if (MemWrite) begin
          if (is_word) begin
            MemWE = 1'b1;
          end else begin
            Stall      = 1'b1;
            capture    = 1'b1;
            next_state = WRITE;
          end
        end else if (MemRead) begin
          LoadData = load_value;
        end
      end
      WRITE: begin
        // The store is still presented; it is not decoded again here.
        MemWE        = 1'b1;
        MemAddr      = cap_addr;
        MemWriteData = cap_word;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Capture address and merged word for the write cycle of a sub-word store.
  // NOTE: these are a handful of flops, not a RAM array, so they take the
  // async reset; a reset in WRITE simply drops the pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr <= '0;
      cap_word <= '0;
    end else if (capture) begin
      cap_addr <= MemAddr;
      cap_word <= merged;
    end
  end

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               FaultSticky <= 1'b0;
    else if (MisalignedFault) FaultSticky <= 1'b1;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural 64 x 32-bit
// data memory (synchronous write, asynchronous read).
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] MemReadData;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic        MemWE;
  logic [31:0] LoadData;
  logic        Stall;
  logic        MisalignedFault;
  logic        FaultSticky;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [64];

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .funct3         (funct3),
    .ALUResult      (ALUResult),
    .WriteData      (WriteData),
    .MemReadData    (MemReadData),
    .MemAddr        (MemAddr),
    .MemWriteData   (MemWriteData),
    .MemWE          (MemWE),
    .LoadData       (LoadData),
    .Stall          (Stall),
    .MisalignedFault(MisalignedFault),
    .FaultSticky    (FaultSticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: async read, write on rising edge.
  assign MemReadData = mem[MemAddr[7:2]];
  always @(posedge clk) begin
    if (MemWE) mem[MemAddr[7:2]] <= MemWriteData;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, settle, then return.
  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    MemRead   = rd;
    MemWrite  = wr;
    funct3    = f3;
    ALUResult = addr;
    WriteData = wd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    funct3    = 3'b000;
    ALUResult = 32'h0;
    WriteData = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we",     {31'b0, MemWE},           32'h0);
    check("rst_stall",  {31'b0, Stall},           32'h0);
    check("rst_fault",  {31'b0, MisalignedFault}, 32'h0);
    check("rst_sticky", {31'b0, FaultSticky},     32'h0);
    check("rst_load",   LoadData,                 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload through the DUT with aligned single-cycle word stores.
    drive(1'b0, 1'b1, 3'b010, 32'h10, 32'hAABBCCDD);
    check("sw_pre_we",    {31'b0, MemWE}, 32'h1);
    check("sw_pre_stall", {31'b0, Stall}, 32'h0);
    check("sw_pre_data",  MemWriteData,   32'hAABBCCDD);
    check("sw_pre_addr",  MemAddr,        32'h10);
    drive(1'b0, 1'b1, 3'b010, 32'h18, 32'h11223344);

    // Loads from 0xAABBCCDD at 0x10.
    drive(1'b1, 1'b0, 3'b000, 32'h11, 32'h0);
    check("lb_11",       LoadData,        32'hFFFFFFCC);
    check("lb_11_stall", {31'b0, Stall},  32'h0);
    check("lb_11_addr",  MemAddr,         32'h10);
    drive(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
    check("lbu_13",      LoadData,        32'h000000AA);
    drive(1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
    check("lh_12",       LoadData,        32'hFFFFAABB);
    check("lh_12_stall", {31'b0, Stall},  32'h0);
    drive(1'b1, 1'b0, 3'b101, 32'h10, 32'h0);
    check("lhu_10",      LoadData,        32'h0000CCDD);
    drive(1'b1, 1'b0, 3'b000, 32'h10, 32'h0);
    check("lb_10",       LoadData,        32'hFFFFFFDD);
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_10",       LoadData,        32'hAABBCCDD);

    // SB @0x12: stall cycle, then the merged write.
    drive(1'b0, 1'b1, 3'b000, 32'h12, 32'h12345655);
    check("sb12_c1_stall", {31'b0, Stall}, 32'h1);
    check("sb12_c1_we",    {31'b0, MemWE}, 32'h0);
    drive(1'b0, 1'b1, 3'b000, 32'h12, 32'h12345655);
    check("sb12_c2_stall", {31'b0, Stall}, 32'h0);
    check("sb12_c2_we",    {31'b0, MemWE}, 32'h1);
    check("sb12_c2_data",  MemWriteData,   32'hAA55CCDD);
    check("sb12_c2_addr",  MemAddr,        32'h10);
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    check("sb12_readback", LoadData,       32'hAA55CCDD);
    check("sb12_after_stall", {31'b0, Stall}, 32'h0);

    // SW @0x14 then SH @0x16.
    drive(1'b0, 1'b1, 3'b010, 32'h14, 32'hDEADBEEF);
    check("sw14_we",    {31'b0, MemWE}, 32'h1);
    check("sw14_stall", {31'b0, Stall}, 32'h0);
    drive(1'b0, 1'b1, 3'b001, 32'h16, 32'h0000BEEF);
    check("sh16_c1_stall", {31'b0, Stall}, 32'h1);
    drive(1'b0, 1'b1, 3'b001, 32'h16, 32'h0000BEEF);
    check("sh16_c2_we",    {31'b0, MemWE}, 32'h1);
    check("sh16_c2_data",  MemWriteData,   32'hBEEFBEEF);
    drive(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
    check("sh16_readback", LoadData,       32'hBEEFBEEF);

    // Faults.
    check("sticky_before", {31'b0, FaultSticky}, 32'h0);
    drive(1'b0, 1'b1, 3'b001, 32'h11, 32'h0000FFFF);
    check("sh11_fault",  {31'b0, MisalignedFault}, 32'h1);
    check("sh11_we",     {31'b0, MemWE},           32'h0);
    check("sh11_stall",  {31'b0, Stall},           32'h0);
    check("sh11_sticky_same", {31'b0, FaultSticky}, 32'h0);
    drive(1'b1, 1'b0, 3'b010, 32'h12, 32'h0);
    check("lw12_fault",  {31'b0, MisalignedFault}, 32'h1);
    check("lw12_load",   LoadData,                 32'h0);
    check("sticky_next", {31'b0, FaultSticky},     32'h1);
    drive(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
    check("ld011_fault", {31'b0, MisalignedFault}, 32'h1);
    drive(1'b0, 1'b1, 3'b100, 32'h10, 32'h0);
    check("st100_fault", {31'b0, MisalignedFault}, 32'h1);
    check("st100_we",    {31'b0, MemWE},           32'h0);
    drive(1'b1, 1'b1, 3'b010, 32'h10, 32'h0);
    check("rdwr_fault",  {31'b0, MisalignedFault}, 32'h1);
    check("rdwr_we",     {31'b0, MemWE},           32'h0);
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    check("fault_mem_unchanged", LoadData,         32'hAA55CCDD);
    check("ok_no_fault", {31'b0, MisalignedFault}, 32'h0);

    // Restore 0x10, then back-to-back SB @0x10 and SB @0x11.
    drive(1'b0, 1'b1, 3'b010, 32'h10, 32'hAABBCCDD);
    drive(1'b0, 1'b1, 3'b000, 32'h10, 32'hFFFFFF01);
    check("b2b_c1_stall", {31'b0, Stall}, 32'h1);
    drive(1'b0, 1'b1, 3'b000, 32'h10, 32'hFFFFFF01);
    check("b2b_c2_data",  MemWriteData,   32'hAABBCC01);
    check("b2b_c2_we",    {31'b0, MemWE}, 32'h1);
    drive(1'b0, 1'b1, 3'b000, 32'h11, 32'h00000002);
    check("b2b_c3_stall", {31'b0, Stall}, 32'h1);
    check("b2b_c3_we",    {31'b0, MemWE}, 32'h0);
    drive(1'b0, 1'b1, 3'b000, 32'h11, 32'h00000002);
    check("b2b_c4_data",  MemWriteData,   32'hAABB0201);
    check("b2b_c4_stall", {31'b0, Stall}, 32'h0);
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    check("b2b_readback", LoadData,       32'hAABB0201);
    check("sticky_holds", {31'b0, FaultSticky}, 32'h1);

    // Reset during the WRITE cycle of an SB: the write is dropped.
    drive(1'b0, 1'b1, 3'b000, 32'h18, 32'h00000077);
    check("rstw_c1_stall", {31'b0, Stall}, 32'h1);
    @(negedge clk);
    rst_n    = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    #1;
    check("rstw_we",     {31'b0, MemWE},       32'h0);
    check("rstw_stall",  {31'b0, Stall},       32'h0);
    check("rstw_sticky", {31'b0, FaultSticky}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("rstw_idle_we", {31'b0, MemWE}, 32'h0);
    drive(1'b1, 1'b0, 3'b010, 32'h18, 32'h0);
    check("rstw_no_write", LoadData, 32'h11223344);

    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
